// File: rtl/mem_access_unit.sv
// Load/store unit for the M stage: aligns store data and byte masks, issues one
// word-aligned memory request, and extracts/extends load data, with a WAIT timeout.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  st_size,
    input  logic [2:0]  ld_size,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [1:0]    st_size_q;
    logic [2:0]    ld_size_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ld_data_q, ld_data_d;
    logic          timeout_q, timeout_d;
    logic          capture, bad, stall_c, misalign_c;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   extracted;

    always_comb begin
        bad = 1'b0;
        if (req_we) begin
            case (st_size)
                2'b00:   bad = 1'b0;
                2'b01:   bad = req_addr[0];
                2'b10:   bad = |req_addr[1:0];
                default: bad = 1'b1;
            endcase
        end else begin
            case (ld_size)
                3'b000, 3'b100: bad = 1'b0;
                3'b001, 3'b101: bad = req_addr[0];
                3'b010:         bad = |req_addr[1:0];
                default:        bad = 1'b1;
            endcase
        end
    end

    always_comb begin
        rbyte     = mem_resp_data[{addr_q[1:0], 3'b000} +: 8];
        rhalf     = addr_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
        extracted = mem_resp_data;
        case (ld_size_q)
            3'b000:  extracted = {{24{rbyte[7]}}, rbyte};
            3'b001:  extracted = {{16{rhalf[15]}}, rhalf};
            3'b100:  extracted = {24'd0, rbyte};
            3'b101:  extracted = {16'd0, rhalf};
            default: extracted = mem_resp_data;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_data_d  = ld_data_q;
        timeout_d  = 1'b0;
        capture    = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (bad) begin
                        misalign_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        capture = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                stall_c = 1'b1;
                if (mem_req_ready) begin
                    state_d = we_q ? DONE : WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                // A response arriving on the final allowed cycle still counts.
                if (mem_resp_valid) begin
                    ld_data_d = extracted;
                    state_d   = DONE;
                end else if (cnt_q >= TO_LAST) begin
                    ld_data_d = '0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ld_data_q <= '0;
            timeout_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            st_size_q <= '0;
            ld_size_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
            timeout_q <= timeout_d;
            if (capture) begin
                we_q      <= req_we;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                st_size_q <= st_size;
                ld_size_q <= ld_size;
            end
        end
    end

    // Combinational IDLE decodes are gated so nothing leaks out while reset is held.
    assign stall         = stall_c & reset;
    assign misalign      = misalign_c & reset;
    assign ld_valid      = (state_q == DONE) & ~we_q;
    assign ld_data       = ld_data_q;
    assign timeout       = timeout_q;
    assign mem_req_valid = (state_q == ISSUE);
    assign mem_addr      = mem_req_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_we        = mem_req_valid & we_q;

    always_comb begin
        mem_wmask = 4'b0000;
        mem_wdata = 32'd0;
        if (mem_req_valid && we_q) begin
            case (st_size_q)
                2'b00: begin
                    mem_wmask = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_wmask = 4'b0011 << addr_q[1:0];
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_wmask = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: WAIT-state cycles allowed before a load is abandoned.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, independent of clk.
REQ-004 req_valid  input  1  M-stage memory access present.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  unshifted store data (rs2).
REQ-008 st_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 ld_size  input  3  func3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others reserved.
REQ-010 stall  output  1  pipeline hold request.
REQ-011 ld_valid  output  1  one-cycle pulse, ld_data valid.
REQ-012 ld_data  output  32  aligned, extended load result.
REQ-013 misalign  output  1  one-cycle pulse, request rejected.
REQ-014 timeout  output  1  one-cycle pulse, load abandoned.
REQ-015 mem_req_valid  output  1  memory request; mem_req_ready  input  1  memory accepts.
REQ-016 mem_addr  output  32  {req_addr[31:2],2'b00}; mem_we  output  1; mem_wmask  output  4; mem_wdata  output  32.
REQ-017 mem_resp_valid  input  1; mem_resp_data  input  32  read word.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, DONE; request fields (we, addr, wdata, sizes) SHALL be registered on acceptance and held until DONE.
REQ-019 IDLE, req_valid=1, misaligned: misalign=1 that cycle, no memory access, stall=0, stay IDLE.
REQ-020 Misaligned: half (st/ld) with addr[0]=1; word with addr[1:0]!=0; reserved st_size (when req_we=1) or reserved ld_size (when req_we=0).
REQ-021 IDLE, req_valid=1, aligned: stall=1 combinationally that cycle, capture request, next state ISSUE.
REQ-022 ISSUE: mem_req_valid=1, stall=1; addr/we/wmask/wdata stable until mem_req_ready; ready=1 -> DONE if store, WAIT if load.
REQ-023 WAIT: stall=1; mem_resp_valid=1 -> register extracted data into ld_data, next DONE.
REQ-024 WAIT timeout: 8-bit-or-wider counter cleared on WAIT entry, increments each WAIT cycle without response; reaching TIMEOUT_CYCLES -> timeout=1 one cycle, ld_data=0, next DONE.
REQ-025 DONE: stall=0, ld_valid=1 for loads (0 for stores), req_valid ignored this cycle, next IDLE.
REQ-026 Store mask: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads mask 4'b0000.
REQ-027 Store data: byte replicated into all 4 lanes; half replicated into both halves; word unchanged.
REQ-028 Load extract: select byte lane addr[1:0] / half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-029 mem_resp_valid outside WAIT and mem_req_ready outside ISSUE SHALL be ignored.
REQ-030 Response in same cycle as timeout count reached: response wins, timeout not pulsed.
REQ-031 Minimum latency: store 3 cycles (accept, ISSUE, DONE); load 4 cycles (accept, ISSUE, WAIT, DONE).

Reset
REQ-032 reset=0: state IDLE, counter 0, captured request 0, ld_data 0; all outputs 0 except stall = combinational IDLE decode (0 while reset=0).
REQ-033 Reset mid-transaction: abandon immediately, mem_req_valid drops asynchronously, no ld_valid/timeout pulse; late response after release ignored (REQ-029).

Verification
REQ-034 SW addr 0x104, wdata 0xDEADBEEF, ready immediate -> one ISSUE cycle with mem_addr 0x104, wmask 1111, wdata 0xDEADBEEF; stall high 2 cycles, low in DONE.
REQ-035 SB addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, wmask 1000, wdata 0xA5A5A5A5.
REQ-036 LB addr 0x0301, resp 0x1234_80FF one cycle after ready -> ld_valid in 4th cycle, ld_data 0xFFFFFF80; repeat LBU -> 0x00000080; LHU addr 0x302 -> 0x00001234.
REQ-037 LW addr 0x102 -> misalign pulse 1 cycle, stall 0, mem_req_valid never asserted; SH addr 0x101 same.
REQ-038 LW, TIMEOUT_CYCLES=4, no response -> timeout pulse after 4 WAIT cycles, ld_data 0, ld_valid 1 in DONE; rerun with response on 4th WAIT cycle -> no timeout, data returned.
REQ-039 reset=0 during WAIT -> outputs 0 immediately; response asserted after release produces no ld_valid; next aligned request completes normally.
